// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state and owner encodings for the data-memory port arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU_ACC, HOST_ACC} arb_state_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;
endpackage

// File: rtl/dmem_starve_counter.sv
// dmem_starve_counter: saturating wait counter with clear, flags when it reaches MAX
module dmem_starve_counter #(
  parameter int MAX = 4,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic at_max
);
  logic [W-1:0] count;
  assign at_max = count == W'(MAX);
  always_ff @(posedge clock)
    if (reset || clear) count <= '0;
    else if (inc && !at_max) count <= count + W'(1);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one sync-read data-memory port between the core and a host port
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);
  arb_state_t state, state_nxt;
  logic at_max, grant_host, issue, acc_we;
  dmem_starve_counter #(.MAX(HOST_MAX_WAIT)) u_starve (
    .clock (clock),
    .reset (reset),
    .clear (~host_req | (issue & grant_host)),
    .inc   (host_req),
    .at_max(at_max)
  );
  // a starved host wins outright; otherwise the core has priority
  assign grant_host = host_req & (at_max | ~cpu_req);
  assign issue = ~reset & (state == IDLE) & (cpu_req | host_req);
  always_comb begin
    state_nxt = issue ? (grant_host ? HOST_ACC : CPU_ACC) : IDLE;
    mem_en    = issue;
    mem_we    = issue & (grant_host ? host_we : cpu_we);
    mem_addr  = issue ? (grant_host ? host_addr : cpu_addr) : '0;
    mem_wdata = issue ? (grant_host ? host_wdata : cpu_wdata) : '0;
    cpu_stall = ~reset & cpu_req & (state != CPU_ACC);
    cpu_rdata = (~reset & (state == CPU_ACC) & ~acc_we) ? mem_rdata : '0;
    host_ack  = ~reset & (state == HOST_ACC);
    owner     = reset ? OWN_NONE : state == CPU_ACC ? OWN_CPU : state == HOST_ACC ? OWN_HOST : OWN_NONE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state      <= IDLE;
      acc_we     <= 1'b0;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (issue) acc_we <= mem_we;
      if (host_ack && !acc_we) host_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of the arbiter against a small sync-read memory model
module tb_dmem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we, cpu_stall, host_ack, mem_en, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, host_addr, host_wdata, host_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;
  logic [31:0] mem [0:63];
  int n_chk = 0;
  int n_fail = 0;
  int ack_c;
  logic stall_c4, stall_ack;
  logic [31:0] addr_c4;

  always #5 clock = ~clock;

  dmem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always @(posedge clock)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[7:2]];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;
    mem[12] = 32'hCAFE0030;
    mem_rdata = '0;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h30; host_wdata = 32'h0;
    // reset held two cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_ack", 32'(host_ack), 0);
      chk("rst_stall", 32'(cpu_stall), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_host_rdata", host_rdata, 0);
    end
    reset = 1'b0;
    #1;
    chk("ld_c0_en", 32'(mem_en), 1);
    chk("ld_c0_we", 32'(mem_we), 0);
    chk("ld_c0_addr", mem_addr, 32'h10);
    chk("ld_c0_stall", 32'(cpu_stall), 1);
    chk("ld_c0_owner", 32'(owner), 0);
    tick;
    chk("ld_c1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("ld_c1_stall", 32'(cpu_stall), 0);
    chk("ld_c1_owner", 32'(owner), 1);
    chk("ld_c1_en", 32'(mem_en), 0);
    cpu_req = 1'b0;
    tick;
    chk("hr0_en", 32'(mem_en), 1);
    chk("hr0_addr", mem_addr, 32'h30);
    chk("hr0_ack", 32'(host_ack), 0);
    tick;
    chk("hr0_ack1", 32'(host_ack), 1);
    chk("hr0_owner", 32'(owner), 2);
    chk("cpu_rdata_not_acc", cpu_rdata, 0);
    host_req = 1'b0;
    tick;
    chk("hr0_rdata", host_rdata, 32'hCAFE0030);
    chk("hr0_ack_gone", 32'(host_ack), 0);
    chk("idle_en", 32'(mem_en), 0);
    chk("idle_addr", mem_addr, 0);
    // host write then read of 0x20
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h20; host_wdata = 32'h12345678;
    #1;
    chk("hw_en", 32'(mem_en), 1);
    chk("hw_we", 32'(mem_we), 1);
    chk("hw_wdata", mem_wdata, 32'h12345678);
    chk("hw_ack0", 32'(host_ack), 0);
    tick;
    chk("hw_ack1", 32'(host_ack), 1);
    chk("hw_rdata_held", host_rdata, 32'hCAFE0030);
    host_req = 1'b0;
    tick;
    chk("hw_ack_gone", 32'(host_ack), 0);
    chk("hw_mem", mem[8], 32'h12345678);
    host_req = 1'b1; host_we = 1'b0;
    #1;
    chk("hr_en", 32'(mem_en), 1);
    chk("hr_we", 32'(mem_we), 0);
    tick;
    chk("hr_ack", 32'(host_ack), 1);
    host_req = 1'b0;
    tick;
    chk("hr_rdata", host_rdata, 32'h12345678);
    tick;
    chk("hr_rdata_held", host_rdata, 32'h12345678);
    // simultaneous CPU store and host read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'hA5A5A5A5;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h10;
    #1;
    chk("st_c0_en", 32'(mem_en), 1);
    chk("st_c0_we", 32'(mem_we), 1);
    chk("st_c0_addr", mem_addr, 32'h24);
    chk("st_c0_stall", 32'(cpu_stall), 1);
    tick;
    chk("st_c1_owner", 32'(owner), 1);
    chk("st_c1_stall", 32'(cpu_stall), 0);
    chk("st_c1_rdata", cpu_rdata, 0);
    chk("st_c1_ack", 32'(host_ack), 0);
    cpu_req = 1'b0;
    tick;
    chk("st_c2_en", 32'(mem_en), 1);
    chk("st_c2_addr", mem_addr, 32'h10);
    chk("st_c2_we", 32'(mem_we), 0);
    tick;
    chk("st_c3_ack", 32'(host_ack), 1);
    host_req = 1'b0;
    tick;
    chk("st_host_rdata", host_rdata, 32'hDEADBEEF);
    chk("st_mem", mem[9], 32'hA5A5A5A5);
    // CPU hammers the port; host must be forced in at starve count 4
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h24;
    ack_c = -1; stall_c4 = 1'b0; stall_ack = 1'b0; addr_c4 = '0;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) begin
        stall_c4 = cpu_stall;
        addr_c4 = mem_addr;
      end
      if (host_ack && ack_c < 0) begin
        ack_c = c;
        stall_ack = cpu_stall;
        host_req = 1'b0;
      end
      tick;
    end
    chk("force_ack_cycle", 32'(ack_c), 5);
    chk("force_addr_c4", addr_c4, 32'h24);
    chk("force_stall_issue", 32'(stall_c4), 1);
    chk("force_stall_ack", 32'(stall_ack), 1);
    chk("force_rdata", host_rdata, 32'hA5A5A5A5);
    cpu_req = 1'b0;
    tick;
    tick;
    // reset in the middle of a host write's response cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h28; host_wdata = 32'h600DF00D;
    #1;
    chk("rw_en", 32'(mem_en), 1);
    tick;
    reset = 1'b1;
    #1;
    chk("rw_ack_rst", 32'(host_ack), 0);
    chk("rw_owner_rst", 32'(owner), 0);
    chk("rw_en_rst", 32'(mem_en), 0);
    tick;
    reset = 1'b0; host_req = 1'b0;
    #1;
    chk("rw_ack_after", 32'(host_ack), 0);
    chk("rw_owner_after", 32'(owner), 0);
    chk("rw_host_rdata", host_rdata, 0);
    chk("rw_mem", mem[10], 32'h600DF00D);
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h28;
    #1;
    chk("rw_idle_issue", 32'(mem_en), 1);
    tick;
    chk("rw_reread_ack", 32'(host_ack), 1);
    host_req = 1'b0;
    tick;
    chk("rw_reread_data", host_rdata, 32'h600DF00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
